// File: rtl/tx_port_writer_128_if.sv
// User transaction channel plus buffer write port of the 128-bit TX port writer.
// master is the writer's view; slave is the user/buffer environment.
interface tx_port_writer_128_if #(
    parameter int C_DATA_WIDTH       = 128,
    parameter int C_FIFO_DEPTH_WIDTH = 10
);
    logic                          TXN;
    logic [31:0]                   TXN_LEN;
    logic                          TXN_LAST;
    logic                          TXN_ACK;
    logic [C_DATA_WIDTH-1:0]       TXN_DATA;
    logic                          TXN_DATA_VALID;
    logic                          TXN_DATA_REN;
    logic                          TXN_DONE;
    logic                          LEN_VALID;
    logic [1:0]                    LEN_LSB;
    logic                          LEN_LAST;
    logic [C_DATA_WIDTH-1:0]       WR_DATA;
    logic                          WR_EN;
    logic [C_FIFO_DEPTH_WIDTH-1:0] WR_COUNT;

    modport master (
        input  TXN, TXN_LEN, TXN_LAST, TXN_DATA, TXN_DATA_VALID, WR_COUNT,
        output TXN_ACK, TXN_DATA_REN, TXN_DONE, LEN_VALID, LEN_LSB, LEN_LAST,
               WR_DATA, WR_EN
    );

    modport slave (
        output TXN, TXN_LEN, TXN_LAST, TXN_DATA, TXN_DATA_VALID, WR_COUNT,
        input  TXN_ACK, TXN_DATA_REN, TXN_DONE, LEN_VALID, LEN_LSB, LEN_LAST,
               WR_DATA, WR_EN
    );
endinterface

// File: rtl/tx_port_writer_128.sv
// Splits a user TX transaction into transfers of at most C_MAX_XFER_WORDS words
// and streams the 128-bit beats into the TX port buffer FIFO.
//
// state      | meaning
// IDLE       | waiting for TXN
// XFER_START | size next transfer, announce its length
// DATA       | forward beats of the current transfer
// DONE       | report transaction complete
module tx_port_writer_128 #(
    parameter int C_DATA_WIDTH       = 128,
    parameter int C_FIFO_DEPTH       = 512,
    parameter int C_FIFO_DEPTH_WIDTH = 10,
    parameter int C_MAX_XFER_WORDS   = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    tx_port_writer_128_if.master  txPort
);
    localparam int C_BEAT_CNT_WIDTH = $clog2(C_MAX_XFER_WORDS / 4) + 1;
    localparam logic [31:0] C_MAX_WORDS = 32'(C_MAX_XFER_WORDS);
    // Two slots of headroom: one beat in the output register, one for count latency.
    localparam logic [C_FIFO_DEPTH_WIDTH-1:0] C_WR_COUNT_LIMIT =
        C_FIFO_DEPTH_WIDTH'(C_FIFO_DEPTH - 2);

    typedef enum logic [1:0] {IDLE, XFER_START, DATA, DONE} tState;

    tState                       rState;
    tState                       rStateNext;
    logic [31:0]                 rRemain;
    logic [C_BEAT_CNT_WIDTH-1:0] rBeats;
    logic                        rLast;
    logic                        rTxnAck;
    logic                        rTxnDone;
    logic                        rLenValid;
    logic [1:0]                  rLenLsb;
    logic                        rLenLast;
    logic [C_DATA_WIDTH-1:0]     rWrData;
    logic                        rWrEn;

    logic [31:0]                 wXfer;
    logic [31:0]                 wXferRound;
    logic [C_BEAT_CNT_WIDTH-1:0] wXferBeats;
    logic                        wRen;
    logic                        wAccept;

    assign wXfer      = (rRemain > C_MAX_WORDS) ? C_MAX_WORDS : rRemain;
    assign wXferRound = wXfer + 32'd3;
    assign wXferBeats = C_BEAT_CNT_WIDTH'(wXferRound >> 2);
    assign wRen       = (rState == DATA) && (rBeats != '0) &&
                        (txPort.WR_COUNT < C_WR_COUNT_LIMIT);
    assign wAccept    = wRen && txPort.TXN_DATA_VALID;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rState <= IDLE;
        end else begin
            rState <= rStateNext;
        end
    end

    always_comb begin
        rStateNext = rState;
        case (rState)
            IDLE: begin
                if (txPort.TXN) begin
                    rStateNext = (txPort.TXN_LEN == 32'd0) ? DONE : XFER_START;
                end
            end
            XFER_START: rStateNext = DATA;
            DATA: begin
                if (wAccept && (rBeats == C_BEAT_CNT_WIDTH'(1))) begin
                    rStateNext = (rRemain != 32'd0) ? XFER_START : DONE;
                end
            end
            DONE:    rStateNext = IDLE;
            default: rStateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rRemain   <= '0;
            rBeats    <= '0;
            rLast     <= 1'b0;
            rTxnAck   <= 1'b0;
            rTxnDone  <= 1'b0;
            rLenValid <= 1'b0;
            rLenLsb   <= '0;
            rLenLast  <= 1'b0;
            rWrData   <= '0;
            rWrEn     <= 1'b0;
        end else begin
            rTxnAck   <= (rState == IDLE) && txPort.TXN;
            rTxnDone  <= (rState == DONE);
            rLenValid <= (rState == XFER_START);
            rWrEn     <= wAccept;
            if (wAccept) begin
                rWrData <= txPort.TXN_DATA;
                rBeats  <= rBeats - C_BEAT_CNT_WIDTH'(1);
            end
            if ((rState == IDLE) && txPort.TXN) begin
                rRemain <= txPort.TXN_LEN;
                rLast   <= txPort.TXN_LAST;
            end
            if (rState == XFER_START) begin
                rRemain  <= rRemain - wXfer;
                rBeats   <= wXferBeats;
                rLenLsb  <= wXfer[1:0];
                rLenLast <= rLast && (rRemain == wXfer);
            end
        end
    end

    assign txPort.TXN_ACK      = rTxnAck;
    assign txPort.TXN_DONE     = rTxnDone;
    assign txPort.TXN_DATA_REN = wRen;
    assign txPort.LEN_VALID    = rLenValid;
    assign txPort.LEN_LSB      = rLenLsb;
    assign txPort.LEN_LAST     = rLenLast;
    assign txPort.WR_DATA      = rWrData;
    assign txPort.WR_EN        = rWrEn;
endmodule

// File: tb/tb_tx_port_writer_128.sv
// Randomized bench for tx_port_writer_128 against a transfer-list / beat-stream model.
module tb_tx_port_writer_128;
    localparam int DEPTH = 512;
    localparam int MAXW  = 1024;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    tx_port_writer_128_if #(.C_DATA_WIDTH(128), .C_FIFO_DEPTH_WIDTH(10)) txPort ();

    tx_port_writer_128 #(
        .C_DATA_WIDTH(128), .C_FIFO_DEPTH(DEPTH),
        .C_FIFO_DEPTH_WIDTH(10), .C_MAX_XFER_WORDS(MAXW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .txPort(txPort)
    );

    typedef struct {int lsb; int last; int beats;} tXfer;

    tXfer         expXfer[$];
    int           total = 0;
    int           bad = 0;
    int           acceptLeft, ackCnt, doneCnt, lenCnt, wrTotal, expBeats, planLen;
    int           occ, wcMode, validMode, cyc;
    int           stallFrom, stallTo, stallLevel;
    bit           prevFire, txnPending, valTog;
    logic [127:0] lastFireData, curData;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_ack"},   txPort.TXN_ACK, 0);
        chk({tag, "_done"},  txPort.TXN_DONE, 0);
        chk({tag, "_ren"},   txPort.TXN_DATA_REN, 0);
        chk({tag, "_lenv"},  txPort.LEN_VALID, 0);
        chk({tag, "_lsb"},   txPort.LEN_LSB, 0);
        chk({tag, "_last"},  txPort.LEN_LAST, 0);
        chk({tag, "_wren"},  txPort.WR_EN, 0);
        chk({tag, "_wdata"}, txPort.WR_DATA, 0);
    endtask

    function automatic logic [127:0] newBeat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected transfers straight from the length rules; maxPlan caps huge transactions.
    task automatic planTxn(input logic [31:0] len, input bit last, input int maxPlan);
        longint rem = longint'(len);
        longint x;
        tXfer   t;
        expXfer.delete();
        expBeats = 0;
        planLen  = 0;
        while (rem > 0 && planLen < maxPlan) begin
            x = (rem > MAXW) ? MAXW : rem;
            t.lsb   = int'(x % 4);
            t.last  = (last && rem == x) ? 1 : 0;
            t.beats = int'((x + 3) / 4);
            expXfer.push_back(t);
            expBeats += t.beats;
            planLen++;
            rem -= x;
        end
    endtask

    task automatic clearModel();
        expXfer.delete();
        acceptLeft = 0; prevFire = 0; txnPending = 0;
        ackCnt = 0; doneCnt = 0; lenCnt = 0; wrTotal = 0; occ = 0; cyc = 0;
    endtask

    task automatic tick();
        bit   v;
        int   wc;
        bit   fire;
        tXfer t;
        @(negedge CLK);
        txPort.TXN = txnPending;
        case (validMode)
            0:       v = 1'b1;
            1:       begin valTog = ~valTog; v = valTog; end
            default: v = ($urandom_range(0, 2) != 0);
        endcase
        txPort.TXN_DATA_VALID = v;
        txPort.TXN_DATA       = curData;
        case (wcMode)
            1:       wc = occ;
            2:       wc = (cyc >= stallFrom && cyc < stallTo) ? stallLevel : 0;
            default: wc = 0;
        endcase
        txPort.WR_COUNT = 10'(wc);
        #1;
        if (txPort.TXN_ACK) begin
            chk("ack_expected", txnPending, 1);
            ackCnt++;
            txnPending = 0;
        end
        if (txPort.LEN_VALID) begin
            lenCnt++;
            chk("len_planned", expXfer.size() != 0, 1);
            if (expXfer.size() != 0) begin
                t = expXfer.pop_front();
                chk("len_lsb", txPort.LEN_LSB, t.lsb);
                chk("len_last", txPort.LEN_LAST, t.last);
                chk("len_prev_xfer_complete", acceptLeft, 0);
                acceptLeft = t.beats;
            end
        end
        chk("ren", txPort.TXN_DATA_REN, (acceptLeft > 0) && (wc < DEPTH - 2));
        chk("wr_en", txPort.WR_EN, prevFire);
        if (txPort.WR_EN) begin
            wrTotal++;
            if (prevFire) chk("wr_data", txPort.WR_DATA, lastFireData);
        end
        fire = v && txPort.TXN_DATA_REN;
        prevFire = fire;
        if (fire) begin
            acceptLeft--;
            lastFireData = curData;
            curData = newBeat();
        end
        if (txPort.TXN_DONE) begin
            doneCnt++;
            chk("done_beats", wrTotal, expBeats);
            chk("done_xfers_left", expXfer.size(), 0);
        end
        if (wcMode == 1) begin
            if (txPort.WR_EN) occ++;
            chk("fifo_no_overflow", occ <= DEPTH, 1);
            if (occ > 0 && $urandom_range(0, 1) == 1) occ--;
        end
        cyc++;
    endtask

    task automatic doReset();
        @(negedge CLK);
        RST_N = 1'b0;
        txPort.TXN = 1'b0;
        txPort.TXN_DATA_VALID = 1'b0;
        #1;
        chkOutputsZero("rst_async");
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        clearModel();
    endtask

    task automatic runTxn(input logic [31:0] len, input bit last, input int vmode,
                          input int wmode, input int abortBeats, input int maxPlan);
        clearModel();
        planTxn(len, last, maxPlan);
        validMode = vmode;
        wcMode    = wmode;
        txPort.TXN_LEN  = len;
        txPort.TXN_LAST = last;
        txnPending = 1;
        while (doneCnt == 0 && cyc < 20000) begin
            tick();
            if (abortBeats > 0 && wrTotal >= abortBeats) break;
        end
        if (abortBeats > 0) begin
            chk("abort_reached", wrTotal >= abortBeats, 1);
            doReset();
        end else begin
            chk("done_within_budget", doneCnt, 1);
            repeat (4) tick();
            chk("ack_count", ackCnt, 1);
            chk("done_count", doneCnt, 1);
            chk("len_count", lenCnt, planLen);
            chk("wr_total", wrTotal, expBeats);
            chk("accept_left", acceptLeft, 0);
        end
    endtask

    initial begin
        txPort.TXN = 0; txPort.TXN_LEN = 0; txPort.TXN_LAST = 0;
        txPort.TXN_DATA = '0; txPort.TXN_DATA_VALID = 0; txPort.WR_COUNT = '0;
        valTog = 0; validMode = 0; wcMode = 0;
        stallFrom = 0; stallTo = 0; stallLevel = 0;
        curData = newBeat();
        lastFireData = '0;
        clearModel();
        repeat (2) @(negedge CLK);
        chkOutputsZero("reset");
        RST_N = 1'b1;
        repeat (2) tick();

        runTxn(32'd10, 1'b1, 0, 0, 0, 16);
        runTxn(32'd2050, 1'b1, 2, 1, 0, 16);
        stallFrom = 6; stallTo = 14; stallLevel = DEPTH - 2;
        runTxn(32'd64, 1'b0, 0, 2, 0, 16);
        stallFrom = 4; stallTo = 20; stallLevel = DEPTH - 3;
        runTxn(32'd64, 1'b1, 2, 2, 0, 16);
        stallFrom = 3; stallTo = 30; stallLevel = DEPTH;
        runTxn(32'd33, 1'b1, 2, 2, 0, 16);
        runTxn(32'd16, 1'b0, 1, 0, 0, 16);
        runTxn(32'd0, 1'b0, 0, 0, 0, 16);
        runTxn(32'd100, 1'b1, 0, 0, 10, 16);
        repeat (3) tick();
        runTxn(32'd4, 1'b0, 0, 0, 0, 16);
        runTxn(32'hFFFF_FFFF, 1'b1, 0, 1, 300, 3);
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            runTxn(32'($urandom_range(1, 1500)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), $urandom_range(0, 1), 0, 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
